// File: rtl/spi_rom_responder_pkg.sv
// Shared constants and state encoding for the SPI flash ROM responder.
// Field widths and the READ opcode the responder accepts.
package spi_rom_responder_pkg;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int         CMD_BITS     = 8;
    localparam int         ADDR_LEN     = 24;
    localparam int         BYTE_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_IGNORE = 3'd4
    } state_t;

    // Down-counter load value for a field of nbits bits; terminal count is zero.
    function automatic logic [4:0] bit_load(input int nbits);
        return 5'(nbits - 1);
    endfunction

endpackage

// File: rtl/spi_rom_responder_edge_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with rise/fall pulses.
// Deliberately unreset so a pin that is already high after reset never looks like a fresh edge.
module spi_rom_responder_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   q_d;

    always_ff @(posedge clk) begin
        chain <= {chain[SYNC_STAGES-2:0], d};
        q_d   <= chain[SYNC_STAGES-1];
    end

    assign q    = chain[SYNC_STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/spi_rom_responder.sv
// SPI flash ROM emulator: decodes READ (03h) + 24-bit address, streams memory bytes MSB-first.
//   state     | meaning
//   ST_IDLE   | waiting for a chip-select rise
//   ST_CMD    | shifting in the 8-bit command
//   ST_ADDR   | shifting in the 24-bit address
//   ST_DATA   | streaming bytes on MISO, one bit per SCLK fall
//   ST_IGNORE | unsupported command, outputs quiet until CS drops
module spi_rom_responder
    import spi_rom_responder_pkg::*;
#(
    parameter int ADDR_BITS   = 11,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 spi_cs,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    input  logic                 mem_we,
    input  logic [ADDR_BITS-1:0] mem_waddr,
    input  logic [7:0]           mem_wdata,
    output logic                 busy,
    output logic                 cmd_err
);

    logic cs_rise, cs_fall, sclk_rise, sclk_fall, mosi;
    logic cs_lvl_unused, sclk_lvl_unused, mosi_rise_unused, mosi_fall_unused;

    spi_rom_responder_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .d(spi_cs), .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
    );
    spi_rom_responder_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .d(spi_sclk), .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_rom_responder_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .d(spi_mosi), .q(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t                 state, state_nxt;
    logic [4:0]             bit_cnt;
    logic [6:0]             cmd_sh;
    logic [ADDR_BITS-2:0]   addr_sh;
    logic [ADDR_BITS-1:0]   addr, rd_addr;
    logic [7:0]             out_sh, mem_rdata;
    logic                   load_pend, fetch_pend;
    logic                   cmd_err_nxt, mem_re, addr_done, last_bit;
    logic [7:0]             cmd_byte;
    logic [ADDR_BITS-1:0]   addr_word;
    logic [7:0]             mem [2**ADDR_BITS];

    assign cmd_byte  = {cmd_sh, mosi};
    assign addr_word = {addr_sh, mosi};
    assign last_bit  = (bit_cnt == 5'd0);
    assign addr_done = (state == ST_ADDR) && sclk_rise && last_bit && !cs_fall;

    always_comb begin
        state_nxt   = state;
        cmd_err_nxt = 1'b0;
        if (cs_fall) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cs_rise) state_nxt = ST_CMD;
                ST_CMD: begin
                    if (sclk_rise && last_bit) begin
                        if (cmd_byte == SPI_CMD_READ) begin
                            state_nxt = ST_ADDR;
                        end else begin
                            state_nxt   = ST_IGNORE;
                            cmd_err_nxt = 1'b1;
                        end
                    end
                end
                ST_ADDR: if (sclk_rise && last_bit) state_nxt = ST_DATA;
                default: state_nxt = state;
            endcase
        end
    end

    // The first byte is read straight off the completing address; later bytes are prefetched.
    always_comb begin
        mem_re  = 1'b0;
        rd_addr = addr;
        if (addr_done) begin
            mem_re  = 1'b1;
            rd_addr = addr_word;
        end else if (state == ST_DATA && fetch_pend && !cs_fall) begin
            mem_re = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= 5'd0;
            cmd_sh     <= '0;
            addr_sh    <= '0;
            addr       <= '0;
            out_sh     <= '0;
            spi_miso   <= 1'b0;
            cmd_err    <= 1'b0;
            load_pend  <= 1'b0;
            fetch_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            cmd_err <= cmd_err_nxt;
            case (state)
                ST_IDLE: begin
                    spi_miso   <= 1'b0;
                    load_pend  <= 1'b0;
                    fetch_pend <= 1'b0;
                    if (cs_rise) bit_cnt <= bit_load(CMD_BITS);
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        cmd_sh  <= cmd_byte[6:0];
                        bit_cnt <= last_bit ? bit_load(ADDR_LEN) : bit_cnt - 5'd1;
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        addr_sh <= addr_word[ADDR_BITS-2:0];
                        if (last_bit) begin
                            addr      <= addr_word + ADDR_BITS'(1);
                            load_pend <= 1'b1;
                            bit_cnt   <= bit_load(BYTE_BITS);
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (fetch_pend) begin
                        addr       <= addr + ADDR_BITS'(1);
                        fetch_pend <= 1'b0;
                    end
                    if (load_pend) begin
                        out_sh     <= mem_rdata;
                        load_pend  <= 1'b0;
                        fetch_pend <= 1'b1;
                    end else if (sclk_fall) begin
                        spi_miso <= out_sh[7];
                        if (last_bit) begin
                            out_sh     <= mem_rdata;
                            bit_cnt    <= bit_load(BYTE_BITS);
                            fetch_pend <= 1'b1;
                        end else begin
                            out_sh  <= {out_sh[6:0], 1'b0};
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
                default: ;
            endcase
            if (cs_fall) begin
                bit_cnt    <= 5'd0;
                cmd_sh     <= '0;
                addr_sh    <= '0;
                spi_miso   <= 1'b0;
                load_pend  <= 1'b0;
                fetch_pend <= 1'b0;
            end
        end
    end

    // Memory is not reset; a read in the same cycle as a write sees the old byte.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[rd_addr];
    end

    assign busy        = (state != ST_IDLE);
    assign spi_miso_oe = (state == ST_DATA);

endmodule

// File: tb/tb_spi_rom_responder.sv
// Bench for spi_rom_responder: a mode-0 SPI master model against a flat byte-array reference.
module tb_spi_rom_responder;

    localparam int AB    = 11;
    localparam int DEPTH = 2048;
    localparam int HALF  = 4;

    logic          clk = 1'b0;
    logic          reset_n, spi_cs, spi_sclk, spi_mosi;
    logic          spi_miso, spi_miso_oe, busy, cmd_err;
    logic          mem_we;
    logic [AB-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    logic [7:0] ref_mem [DEPTH];
    int checks = 0;
    int errors = 0;
    int cmd_err_cnt = 0;
    int oe_hi_cnt = 0;
    int miso_hi_cnt = 0;

    spi_rom_responder #(.ADDR_BITS(AB), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_err === 1'b1) cmd_err_cnt++;
        if (spi_miso_oe === 1'b1) oe_hi_cnt++;
        if (spi_miso === 1'b1) miso_hi_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input int a, input logic [7:0] d);
        mem_we    = 1'b1;
        mem_waddr = AB'(a);
        mem_wdata = d;
        tick(1);
        mem_we    = 1'b0;
        ref_mem[a % DEPTH] = d;
    endtask

    task automatic send_bit(input logic b);
        spi_mosi = b;
        tick(HALF);
        spi_sclk = 1'b1;
        tick(HALF);
        spi_sclk = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        spi_mosi = 1'($urandom);
        tick(HALF);
        b = spi_miso;
        spi_sclk = 1'b1;
        tick(HALF);
        spi_sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_addr(input logic [23:0] a, input int nbits);
        for (int i = 23; i >= 24 - nbits; i--) send_bit(a[i]);
    endtask

    task automatic recv_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            v[i] = b;
        end
    endtask

    task automatic start_frame();
        spi_cs = 1'b1;
        tick(HALF);
    endtask

    task automatic end_frame(input string tag);
        spi_cs   = 1'b0;
        spi_sclk = 1'b0;
        tick(HALF);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_oe"}, 32'(spi_miso_oe), 32'd0);
        check({tag, "_idle_miso"}, 32'(spi_miso), 32'd0);
    endtask

    // Full READ frame: expected stream is ref_mem from the aliased address, wrapping at DEPTH.
    task automatic read_check(input logic [23:0] a, input int n, input string tag);
        logic [7:0] got;
        int base;
        base = int'(a) % DEPTH;
        start_frame();
        send_byte(8'h03);
        check({tag, "_cmd_busy"}, 32'(busy), 32'd1);
        check({tag, "_cmd_oe"}, 32'(spi_miso_oe), 32'd0);
        send_addr(a, 24);
        for (int k = 0; k < n; k++) begin
            recv_byte(got);
            check($sformatf("%s_byte%0d", tag, k), 32'(got), 32'(ref_mem[(base + k) % DEPTH]));
        end
        check({tag, "_data_oe"}, 32'(spi_miso_oe), 32'd1);
        check({tag, "_data_busy"}, 32'(busy), 32'd1);
        end_frame(tag);
    endtask

    initial begin
        logic [7:0]  got, old_b;
        logic        b;
        logic [23:0] ra;
        int          oe0, mi0, err0;

        reset_n = 1'b0; spi_cs = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        tick(6);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_oe", 32'(spi_miso_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        reset_n = 1'b1;
        tick(2);

        for (int i = 0; i < DEPTH; i++) mem_write(i, 8'($urandom));

        mem_write(0, 8'hA5); mem_write(1, 8'h3C); mem_write(2, 8'hFF); mem_write(3, 8'h00);
        read_check(24'h000000, 4, "basic");

        mem_write(16'h10, 8'h81);
        read_check(24'h000010, 1, "line");

        mem_write(12'h7FF, 8'h12); mem_write(0, 8'h34);
        read_check(24'h0007FF, 2, "wrap");
        read_check(24'h0017FF, 1, "alias");

        // Unsupported command: one cmd_err pulse, then silence until CS drops.
        err0 = cmd_err_cnt;
        start_frame();
        send_byte(8'h0B);
        tick(1);
        check("bad_cmd_err_pulse", 32'(cmd_err_cnt - err0), 32'd1);
        check("bad_cmd_busy", 32'(busy), 32'd1);
        oe0 = oe_hi_cnt; mi0 = miso_hi_cnt;
        for (int i = 0; i < 40; i++) recv_bit(b);
        check("bad_cmd_oe_quiet", 32'(oe_hi_cnt - oe0), 32'd0);
        check("bad_cmd_miso_quiet", 32'(miso_hi_cnt - mi0), 32'd0);
        check("bad_cmd_err_single", 32'(cmd_err_cnt - err0), 32'd1);
        end_frame("bad_cmd");

        // Aborted address phase leaves no residue in the next frame.
        start_frame();
        send_byte(8'h03);
        send_addr(24'($urandom), 20);
        end_frame("abort");
        read_check(24'h000004, 2, "after_abort");

        // Reset pulse in the middle of a data byte.
        ra = 24'($urandom);
        start_frame();
        send_byte(8'h03);
        send_addr(ra, 24);
        recv_byte(got);
        check("rst_mid_byte0", 32'(got), 32'(ref_mem[int'(ra) % DEPTH]));
        for (int i = 0; i < 3; i++) recv_bit(b);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("rst_mid_miso", 32'(spi_miso), 32'd0);
        check("rst_mid_oe", 32'(spi_miso_oe), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        send_byte(8'h03);
        check("rst_mid_no_resume", 32'(busy), 32'd0);
        end_frame("rst_mid");
        read_check(ra, 2, "rst_mem_intact");

        // Write to the address being streamed: the byte already in flight is the old one.
        old_b = ref_mem[4];
        start_frame();
        send_byte(8'h03);
        send_addr(24'h000004, 24);
        for (int i = 7; i >= 6; i--) begin
            recv_bit(b);
            got[i] = b;
        end
        mem_write(4, ~old_b);
        for (int i = 5; i >= 0; i--) begin
            recv_bit(b);
            got[i] = b;
        end
        check("wr_during_rd_old", 32'(got), 32'(old_b));
        end_frame("wr_during_rd");
        read_check(24'h000004, 1, "wr_new_value");

        for (int t = 0; t < 6; t++) begin
            if (t % 2 == 1) mem_write(int'($urandom_range(DEPTH - 1)), 8'($urandom));
            read_check(24'($urandom), int'($urandom_range(4, 1)), $sformatf("rand%0d", t));
        end

        check("no_stray_cmd_err", 32'(cmd_err_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
